// File: rtl/div_if.sv
// div_if: execute-stage <-> divider handshake bundle.
// Latency: none, wires only; the divider registers result_o/ready_o itself.
// Backpressure: start_i is held by execute until it sees ready_o, then dropped to release the result.
// Ports (signals):
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o is observed
//   annul_i       abort an in-flight division (flush / exception)
//   result_o      {remainder, quotient}
//   ready_o       result_o valid
// Modports: master = execute stage, slave = divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// div: 32x32 restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle.
// Latency: ready_o visible 33 cycles after the start edge (1 cycle for a zero divisor).
// Backpressure: result and ready_o hold while start_i stays high; start_i low releases the result.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset; overrides every state and annul_i
//   bus   div_if.slave: operands, start/annul in; result_o/ready_o out (both registered)
module div #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BYZERO = 2'b01;
  localparam logic [1:0] ON     = 2'b10;
  localparam logic [1:0] END    = 2'b11;

  // cnt counts completed restoring steps; reaching WIDTH means finalize.
  localparam logic [5:0] CNT_LAST = 6'(WIDTH);

  logic [1:0]         state;
  logic [5:0]         cnt;
  // {partial remainder (W+1 bits), remaining dividend / accumulated quotient (W bits)}
  logic [2*WIDTH:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               sgn_mode;
  logic               sign1;
  logic               sign2;

  // Operand magnitudes taken at the sampling edge.
  logic [WIDTH-1:0]   op1_mag;
  logic [WIDTH-1:0]   op2_mag;

  // One restoring step.
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH:0]   step_val;

  // Sign-corrected final values.
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op1_mag = bus.opdata1_i;
    op2_mag = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) begin
      op1_mag = ~bus.opdata1_i + 1'b1;
    end
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) begin
      op2_mag = ~bus.opdata2_i + 1'b1;
    end
  end

  // Shift in the next dividend bit, then trial-subtract the divisor from the
  // W+1-bit partial remainder. The extra top bit of trial is the borrow: clear
  // means the subtraction fits and the quotient bit is 1.
  always_comb begin
    shifted  = {dividend[2*WIDTH-1:0], 1'b0};
    trial    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    step_val = shifted;
    if (!trial[WIDTH+1]) begin
      step_val = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end
  end

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend's sign. 0x80000000 / -1 wraps back to 0x80000000 by design.
  always_comb begin
    quo_mag = dividend[WIDTH-1:0];
    rem_mag = dividend[2*WIDTH-1:WIDTH];
    quo_fix = quo_mag;
    rem_fix = rem_mag;
    if (sgn_mode && (sign1 ^ sign2)) begin
      quo_fix = ~quo_mag + 1'b1;
    end
    if (sgn_mode && sign1) begin
      rem_fix = ~rem_mag + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FREE;
      cnt          <= '0;
      dividend     <= '0;
      divisor      <= '0;
      sgn_mode     <= 1'b0;
      sign1        <= 1'b0;
      sign2        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          // A start that coincides with a flush is dropped.
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              dividend <= {{(WIDTH+1){1'b0}}, op1_mag};
              divisor  <= op2_mag;
              sgn_mode <= bus.signed_div_i;
              sign1    <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
              sign2    <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
              cnt      <= '0;
              state    <= ON;
            end
          end
        end

        BYZERO: begin
          // Division by zero returns all-zero without trapping.
          bus.result_o <= '0;
          bus.ready_o  <= 1'b1;
          state        <= END;
        end

        ON: begin
          if (bus.annul_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
            cnt          <= '0;
            state        <= FREE;
          end else if (cnt != CNT_LAST) begin
            dividend <= step_val;
            cnt      <= cnt + 6'd1;
          end else begin
            bus.result_o <= {rem_fix, quo_fix};
            bus.ready_o  <= 1'b1;
            cnt          <= '0;
            state        <= END;
          end
        end

        END: begin
          // Only dropping start releases the result; annul is ignored here
          // because the result is already committed to the execute stage.
          if (!bus.start_i) begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
            state        <= FREE;
          end
        end

        default: begin
          bus.result_o <= '0;
          bus.ready_o  <= 1'b0;
          cnt          <= '0;
          state        <= FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the div block.
// Latency: n/a.
// Backpressure: n/a.
module tb_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  // Steps over the start edge, then counts edges until ready_o (bounded).
  task automatic wait_ready(input string tag, input int exp_lat,
                            input logic [63:0] exp_res, input logic scramble);
    int n = 0;
    step();
    if (scramble) begin
      bus.opdata1_i    = 32'h1234_5678;
      bus.opdata2_i    = 32'h0000_0003;
      bus.signed_div_i = 1'b0;
    end
    while (!bus.ready_o && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, bus.result_o, exp_res);
  endtask

  // One more edge with start held, then release and confirm the clear.
  task automatic hold_and_release(input string tag, input logic [63:0] exp_res);
    step();
    check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, " hold result"}, bus.result_o, exp_res);
    bus.start_i = 1'b0;
    step();
    check({tag, " release ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " release result"}, bus.result_o, 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    step();
    step();
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    rst = 1'b0;
    step();

    // Unsigned 100 / 7 = 14 r 2
    issue(1'b0, 32'd100, 32'd7);
    wait_ready("u100/7", 33, 64'h00000002_0000000E, 1'b0);
    hold_and_release("u100/7", 64'h00000002_0000000E);

    // Signed -7 / 2 = -3 r -1
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_ready("s-7/2", 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    hold_and_release("s-7/2", 64'hFFFFFFFF_FFFFFFFD);

    // Same bits unsigned: 4294967289 / 2 = 2147483644 r 1
    issue(1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_ready("uFFFFFFF9/2", 33, 64'h00000001_7FFFFFFC, 1'b0);
    hold_and_release("uFFFFFFF9/2", 64'h00000001_7FFFFFFC);

    // Signed 7 / -2 = -3 r 1
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_ready("s7/-2", 33, 64'h00000001_FFFFFFFD, 1'b0);
    hold_and_release("s7/-2", 64'h00000001_FFFFFFFD);

    // Signed -8 / -3 = 2 r -2
    issue(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
    wait_ready("s-8/-3", 33, 64'hFFFFFFFE_00000002, 1'b0);
    hold_and_release("s-8/-3", 64'hFFFFFFFE_00000002);

    // Divide by zero: ready after BYZERO -> END, result zero
    issue(1'b0, 32'd12345, 32'd0);
    wait_ready("div0", 1, 64'd0, 1'b0);
    hold_and_release("div0", 64'd0);

    // Annul on the 10th ON edge, then immediately start 20 / 3
    issue(1'b0, 32'd1000, 32'd10);
    step();
    repeat (9) step();
    check("annul pre ready", 64'(bus.ready_o), 64'd0);
    bus.annul_i = 1'b1;
    step();
    check("annul ready", 64'(bus.ready_o), 64'd0);
    check("annul result", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    issue(1'b0, 32'd20, 32'd3);
    wait_ready("u20/3", 33, 64'h00000002_00000006, 1'b0);
    hold_and_release("u20/3", 64'h00000002_00000006);

    // Signed overflow, operands disturbed while ON
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready("ovf", 33, 64'h00000000_80000000, 1'b1);
    hold_and_release("ovf", 64'h00000000_80000000);

    // Reset on the 15th ON edge
    issue(1'b0, 32'd1000, 32'd10);
    step();
    repeat (14) step();
    rst = 1'b1;
    step();
    check("rst on ready", 64'(bus.ready_o), 64'd0);
    check("rst on result", bus.result_o, 64'd0);
    rst = 1'b0;
    issue(1'b0, 32'd50, 32'd7);
    wait_ready("u50/7", 33, 64'h00000001_00000007, 1'b0);

    // Reset while holding in END
    rst = 1'b1;
    step();
    check("rst end ready", 64'(bus.ready_o), 64'd0);
    check("rst end result", bus.result_o, 64'd0);
    rst = 1'b0;
    issue(1'b0, 32'd1000, 32'd10);
    wait_ready("u1000/10", 33, 64'h00000000_00000064, 1'b0);
    hold_and_release("u1000/10", 64'h00000000_00000064);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
